// File: rtl/toast_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package toast_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   // One pending register-file write; valid=0 marks a slot that must not write
   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   // Which source owns the register-file write port in a given cycle
   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_PIPE = 2'd1,
      GRANT_FIFO = 2'd2
   } grant_e;

   // x0 is hardwired to zero, so writes to it are never emitted
   function automatic logic isWritable(input logic [REG_ADDR_W-1:0] addr);
      return (addr != '0);
   endfunction

endpackage

// File: rtl/toast_wb_fifo.sv
// Circular buffer of buffered long-latency results. Besides push/pop it can
// invalidate every entry targeting a given register, which keeps older LU
// results from overwriting a younger pipeline write to the same register.
module toast_wb_fifo
   import toast_pkg::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  wb_req_t               pushReq_i,
   input  logic                  pop_i,
   input  logic                  clrEn_i,
   input  logic [REG_ADDR_W-1:0] clrAddr_i,
   output wb_req_t               head_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   wb_req_t            mem_q [DEPTH];
   wb_req_t            mem_d [DEPTH];
   logic [PTR_W-1:0]   wrPtr_q;
   logic [PTR_W-1:0]   wrPtr_d;
   logic [PTR_W-1:0]   rdPtr_q;
   logic [PTR_W-1:0]   rdPtr_d;
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   count_d;
   logic               doPush;
   logic               doPop;
   wb_req_t            pushEntry;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rdPtr_q];

   // Next-state: rd-match invalidation, push into the tail, pointer/count update
   always_comb begin
      doPush    = push_i & ~full_o;
      doPop     = pop_i & ~empty_o;
      pushEntry = pushReq_i;
      if (clrEn_i && (pushReq_i.addr == clrAddr_i)) begin
         pushEntry.valid = 1'b0;
      end
      mem_d = mem_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (clrEn_i && (mem_q[i].addr == clrAddr_i)) begin
            mem_d[i].valid = 1'b0;
         end
      end
      if (doPush) begin
         mem_d[wrPtr_q] = pushEntry;
      end
      wrPtr_d = doPush ? (wrPtr_q + PTR_W'(1)) : wrPtr_q;
      rdPtr_d = doPop  ? (rdPtr_q + PTR_W'(1)) : rdPtr_q;
      count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
   end

   // Storage and pointer registers; reset drops every buffered entry
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

endmodule

// File: rtl/toast_wb_arbiter.sv
// Owns the single register-file write port. Pipeline writeback normally wins;
// long-latency results wait in a small FIFO and drain in idle slots, and a
// starvation counter eventually stalls writeback to force a drain.
module toast_wb_arbiter
   import toast_pkg::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
)
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  WB_rd_addr_i,
   input  logic [31:0] WB_rd_wr_data_i,
   input  logic        WB_rd_wr_en_i,
   output logic        WB_stall_o,
   input  logic        LU_valid_i,
   input  logic [4:0]  LU_rd_addr_i,
   input  logic [31:0] LU_data_i,
   output logic        LU_ready_o,
   output logic        LU_pending_o,
   output logic [4:0]  RF_rd_addr_o,
   output logic [31:0] RF_wr_data_o,
   output logic        RF_wr_en_o
);

   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   logic [STARVE_W-1:0] starveCnt_q;
   logic [STARVE_W-1:0] starveCnt_d;
   logic [4:0]          rfAddr_q;
   logic [4:0]          rfAddr_d;
   logic [31:0]         rfData_q;
   logic [31:0]         rfData_d;
   logic                rfEn_q;
   logic                rfEn_d;

   logic                fifoFull;
   logic                fifoEmpty;
   wb_req_t             fifoHead;
   wb_req_t             luEntry;
   logic                headReq;
   logic                pipeReq;
   logic                stall;
   logic                push;
   logic                pop;
   logic                clrEn;
   grant_e              grant;

   // Stall depends only on registered state (reset merely masks it)
   assign headReq      = ~fifoEmpty;
   assign stall        = ~rst_i & headReq & (starveCnt_q == STARVE_W'(STARVE_LIMIT));
   assign pipeReq      = WB_rd_wr_en_i & isWritable(WB_rd_addr_i) & ~stall;

   assign WB_stall_o   = stall;
   assign LU_ready_o   = ~rst_i & ~fifoFull;
   assign LU_pending_o = ~rst_i & headReq;

   assign RF_rd_addr_o = rfAddr_q;
   assign RF_wr_data_o = rfData_q;
   assign RF_wr_en_o   = rfEn_q;

   // Grant selection: forced drain, then pipeline, then opportunistic drain
   always_comb begin
      grant = GRANT_NONE;
      if (stall) begin
         grant = GRANT_FIFO;
      end else if (pipeReq) begin
         grant = GRANT_PIPE;
      end else if (headReq) begin
         grant = GRANT_FIFO;
      end
      pop           = (grant == GRANT_FIFO);
      clrEn         = (grant == GRANT_PIPE);
      push          = LU_valid_i & LU_ready_o;
      luEntry.valid = isWritable(LU_rd_addr_i);
      luEntry.addr  = LU_rd_addr_i;
      luEntry.data  = LU_data_i;
   end

   toast_wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (push),
      .pushReq_i (luEntry),
      .pop_i     (pop),
      .clrEn_i   (clrEn),
      .clrAddr_i (WB_rd_addr_i),
      .head_o    (fifoHead),
      .full_o    (fifoFull),
      .empty_o   (fifoEmpty)
   );

   // Register-file port next state; address/data hold when nothing is granted
   always_comb begin
      rfAddr_d = rfAddr_q;
      rfData_d = rfData_q;
      rfEn_d   = 1'b0;
      case (grant)
         GRANT_PIPE: begin
            rfAddr_d = WB_rd_addr_i;
            rfData_d = WB_rd_wr_data_i;
            rfEn_d   = 1'b1;
         end
         GRANT_FIFO: begin
            rfAddr_d = fifoHead.addr;
            rfData_d = fifoHead.data;
            rfEn_d   = fifoHead.valid;
         end
         default: begin
         end
      endcase
   end

   // Count how long the FIFO head keeps losing to the pipeline, saturating
   always_comb begin
      starveCnt_d = starveCnt_q;
      if (pop || fifoEmpty) begin
         starveCnt_d = '0;
      end else if (headReq && (grant == GRANT_PIPE) &&
                   (starveCnt_q != STARVE_W'(STARVE_LIMIT))) begin
         starveCnt_d = starveCnt_q + STARVE_W'(1);
      end
   end

   // Output and starvation registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rfAddr_q    <= '0;
         rfData_q    <= '0;
         rfEn_q      <= 1'b0;
         starveCnt_q <= '0;
      end else begin
         rfAddr_q    <= rfAddr_d;
         rfData_q    <= rfData_d;
         rfEn_q      <= rfEn_d;
         starveCnt_q <= starveCnt_d;
      end
   end

endmodule

// File: tb/tb_toast_wb_arbiter.sv
// Self-checking bench for the writeback arbiter: a cycle table drives inputs
// and checks stall/ready/pending/write-enable, while every expected register
// write is queued and matched against what actually appears on the RF port.
module tb_toast_wb_arbiter;

   localparam int FIFO_DEPTH   = 2;
   localparam int STARVE_LIMIT = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [4:0]  WB_rd_addr_i;
   logic [31:0] WB_rd_wr_data_i;
   logic        WB_rd_wr_en_i;
   logic        WB_stall_o;
   logic        LU_valid_i;
   logic [4:0]  LU_rd_addr_i;
   logic [31:0] LU_data_i;
   logic        LU_ready_o;
   logic        LU_pending_o;
   logic [4:0]  RF_rd_addr_o;
   logic [31:0] RF_wr_data_o;
   logic        RF_wr_en_o;

   typedef struct {
      logic        rst;
      logic        wbEn;
      logic [4:0]  wbAddr;
      logic [31:0] wbData;
      logic        luValid;
      logic [4:0]  luAddr;
      logic [31:0] luData;
      logic        expStall;
      logic        expReady;
      logic        expPending;
      logic        expWr;
      logic [4:0]  expAddr;
      logic [31:0] expData;
      logic        chkHold;
   } vec_t;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   vec_t        vecs[$];
   wr_t         sbQ[$];
   wr_t         monExp;
   int          assertions = 0;
   int          failures   = 0;
   logic [4:0]  lastAddr   = '0;
   logic [31:0] lastData   = '0;

   toast_wb_arbiter #(
      .FIFO_DEPTH   (FIFO_DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .WB_rd_addr_i    (WB_rd_addr_i),
      .WB_rd_wr_data_i (WB_rd_wr_data_i),
      .WB_rd_wr_en_i   (WB_rd_wr_en_i),
      .WB_stall_o      (WB_stall_o),
      .LU_valid_i      (LU_valid_i),
      .LU_rd_addr_i    (LU_rd_addr_i),
      .LU_data_i       (LU_data_i),
      .LU_ready_o      (LU_ready_o),
      .LU_pending_o    (LU_pending_o),
      .RF_rd_addr_o    (RF_rd_addr_o),
      .RF_wr_data_o    (RF_wr_data_o),
      .RF_wr_en_o      (RF_wr_en_o)
   );

   // Free-running clock
   always #5 clk_i = ~clk_i;

   function automatic vec_t mkVec(input int rst, input int wbEn, input int wbAddr,
                                  input logic [31:0] wbData, input int luValid,
                                  input int luAddr, input logic [31:0] luData,
                                  input int expStall, input int expReady,
                                  input int expPending, input int expWr,
                                  input int expAddr, input logic [31:0] expData,
                                  input int chkHold);
      vec_t v;
      v.rst        = (rst != 0);
      v.wbEn       = (wbEn != 0);
      v.wbAddr     = 5'(wbAddr);
      v.wbData     = wbData;
      v.luValid    = (luValid != 0);
      v.luAddr     = 5'(luAddr);
      v.luData     = luData;
      v.expStall   = (expStall != 0);
      v.expReady   = (expReady != 0);
      v.expPending = (expPending != 0);
      v.expWr      = (expWr != 0);
      v.expAddr    = 5'(expAddr);
      v.expData    = expData;
      v.chkHold    = (chkHold != 0);
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      assertions++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rst_i           = v.rst;
      WB_rd_wr_en_i   = v.wbEn;
      WB_rd_addr_i    = v.wbAddr;
      WB_rd_wr_data_i = v.wbData;
      LU_valid_i      = v.luValid;
      LU_rd_addr_i    = v.luAddr;
      LU_data_i       = v.luData;
   endtask

   // One cycle: drive, check combinational status, clock, check the RF port
   task automatic runVec(input vec_t v, input string tag);
      applyStimulus(v);
      if (v.expWr) sbQ.push_back({v.expAddr, v.expData});
      #1;
      checkOutput({tag, " stall"},   32'(WB_stall_o),   32'(v.expStall));
      checkOutput({tag, " ready"},   32'(LU_ready_o),   32'(v.expReady));
      checkOutput({tag, " pending"}, 32'(LU_pending_o), 32'(v.expPending));
      @(posedge clk_i);
      #1;
      checkOutput({tag, " wr_en"}, 32'(RF_wr_en_o), 32'(v.expWr));
      if (v.rst) begin
         lastAddr = '0;
         lastData = '0;
      end else if (v.expWr) begin
         lastAddr = v.expAddr;
         lastData = v.expData;
      end
      if (v.chkHold) begin
         checkOutput({tag, " hold addr"}, 32'(RF_rd_addr_o), 32'(lastAddr));
         checkOutput({tag, " hold data"}, RF_wr_data_o, lastData);
      end
   endtask

   // Scoreboard: every RF write must match the oldest outstanding expectation
   always @(posedge clk_i) begin
      #2;
      if (RF_wr_en_o === 1'b1) begin
         if (sbQ.size() == 0) begin
            assertions++;
            failures++;
            $display("[TB] FAIL unexpected write: got x%0d=0x%0h, required no write",
                     RF_rd_addr_o, RF_wr_data_o);
         end else begin
            monExp = sbQ.pop_front();
            checkOutput("sb addr", 32'(RF_rd_addr_o), 32'(monExp.addr));
            checkOutput("sb data", RF_wr_data_o, monExp.data);
         end
      end
   end

   // Absolute time bound so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no end of test, required completion in time");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int waited;
      int a;
      logic [4:0]  wa;
      logic [31:0] wd;

      // rst wbEn wbA wbD  luV luA luD  stall ready pend  wr wrA wrD  hold
      vecs.push_back(mkVec(1, 0,  0, 'h0,        0,  0, 'h0,  0, 0, 0,  0,  0, 'h0,        1));
      vecs.push_back(mkVec(1, 0,  0, 'h0,        0,  0, 'h0,  0, 0, 0,  0,  0, 'h0,        1));
      vecs.push_back(mkVec(0, 1,  5, 'hDEADBEEF, 0,  0, 'h0,  0, 1, 0,  1,  5, 'hDEADBEEF, 0));
      vecs.push_back(mkVec(0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 0,  0,  0, 'h0,        1));
      vecs.push_back(mkVec(0, 0,  0, 'h0,        1,  7, 'h11, 0, 1, 0,  0,  0, 'h0,        1));
      vecs.push_back(mkVec(0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 1,  1,  7, 'h11,       0));
      vecs.push_back(mkVec(0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 0,  0,  0, 'h0,        1));
      vecs.push_back(mkVec(0, 0,  0, 'h0,        1,  7, 'h22, 0, 1, 0,  0,  0, 'h0,        0));
      vecs.push_back(mkVec(0, 1,  1, 'h101,      0,  0, 'h0,  0, 1, 1,  1,  1, 'h101,      0));
      vecs.push_back(mkVec(0, 1,  2, 'h102,      0,  0, 'h0,  0, 1, 1,  1,  2, 'h102,      0));
      vecs.push_back(mkVec(0, 1,  3, 'h103,      0,  0, 'h0,  0, 1, 1,  1,  3, 'h103,      0));
      vecs.push_back(mkVec(0, 1,  4, 'h104,      0,  0, 'h0,  0, 1, 1,  1,  4, 'h104,      0));
      vecs.push_back(mkVec(0, 1,  5, 'h105,      0,  0, 'h0,  1, 1, 1,  1,  7, 'h22,       0));
      vecs.push_back(mkVec(0, 1,  5, 'h105,      0,  0, 'h0,  0, 1, 0,  1,  5, 'h105,      0));
      vecs.push_back(mkVec(0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 0,  0,  0, 'h0,        1));
      vecs.push_back(mkVec(0, 1, 11, 'hB0,       1, 10, 'hA0, 0, 1, 0,  1, 11, 'hB0,       0));
      vecs.push_back(mkVec(0, 1, 13, 'hB1,       1, 12, 'hA1, 0, 1, 1,  1, 13, 'hB1,       0));
      vecs.push_back(mkVec(0, 1, 15, 'hB2,       1, 14, 'hA2, 0, 0, 1,  1, 15, 'hB2,       0));
      vecs.push_back(mkVec(0, 0,  0, 'h0,        1, 14, 'hA2, 0, 0, 1,  1, 10, 'hA0,       0));
      vecs.push_back(mkVec(0, 0,  0, 'h0,        1, 14, 'hA2, 0, 1, 1,  1, 12, 'hA1,       0));
      vecs.push_back(mkVec(0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 1,  1, 14, 'hA2,       0));
      vecs.push_back(mkVec(0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 0,  0,  0, 'h0,        1));
      vecs.push_back(mkVec(0, 0,  0, 'h0,        1,  9, 'hAA, 0, 1, 0,  0,  0, 'h0,        0));
      vecs.push_back(mkVec(0, 1,  9, 'hBB,       0,  0, 'h0,  0, 1, 1,  1,  9, 'hBB,       0));
      vecs.push_back(mkVec(0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 1,  0,  0, 'h0,        0));
      vecs.push_back(mkVec(0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 0,  0,  0, 'h0,        0));
      vecs.push_back(mkVec(0, 1,  9, 'hDD,       1,  9, 'hCC, 0, 1, 0,  1,  9, 'hDD,       0));
      vecs.push_back(mkVec(0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 1,  0,  0, 'h0,        0));
      vecs.push_back(mkVec(0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 0,  0,  0, 'h0,        0));
      vecs.push_back(mkVec(0, 1,  0, 'h55,       1,  0, 'h66, 0, 1, 0,  0,  0, 'h0,        0));
      vecs.push_back(mkVec(0, 1,  0, 'h77,       0,  0, 'h0,  0, 1, 1,  0,  0, 'h0,        0));
      vecs.push_back(mkVec(0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 0,  0,  0, 'h0,        0));
      vecs.push_back(mkVec(0, 1, 20, 'h201,      1,  3, 'h31, 0, 1, 0,  1, 20, 'h201,      0));
      vecs.push_back(mkVec(0, 1, 21, 'h202,      1,  4, 'h41, 0, 1, 1,  1, 21, 'h202,      0));
      vecs.push_back(mkVec(1, 0,  0, 'h0,        0,  0, 'h0,  0, 0, 0,  0,  0, 'h0,        0));
      vecs.push_back(mkVec(0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 0,  0,  0, 'h0,        1));
      vecs.push_back(mkVec(0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 0,  0,  0, 'h0,        0));
      vecs.push_back(mkVec(0, 0,  0, 'h0,        0,  0, 'h0,  0, 1, 0,  0,  0, 'h0,        0));

      for (int k = 0; k < vecs.size(); k++) begin
         runVec(vecs[k], $sformatf("v%0d", k));
      end

      // Forced drain with a continuous pipeline stream: the buffered x8 wins
      // exactly once the head has lost STARVE_LIMIT times, then the held
      // pipeline write lands on the next cycle.
      runVec(mkVec(0, 0, 0, 'h0, 1, 8, 'h88, 0, 1, 0, 0, 0, 'h0, 0), "lu8");
      for (int i = 0; i <= STARVE_LIMIT + 1; i++) begin
         a = 16 + ((i < STARVE_LIMIT) ? i : STARVE_LIMIT);
         if (i == STARVE_LIMIT) begin
            wa = 5'd8;
            wd = 32'h88;
         end else begin
            wa = 5'(a);
            wd = 32'h1000 + 32'(a);
         end
         runVec(mkVec(0, 1, a, 32'h1000 + 32'(a), 0, 0, 'h0,
                      (i == STARVE_LIMIT) ? 1 : 0, 1,
                      (i <= STARVE_LIMIT) ? 1 : 0,
                      1, int'(wa), wd, 0),
                $sformatf("starve%0d", i));
      end
      runVec(mkVec(0, 0, 0, 'h0, 0, 0, 'h0, 0, 1, 0, 0, 0, 'h0, 0), "idle");

      // Every queued write must have appeared within a bounded number of cycles
      waited = 0;
      while (sbQ.size() != 0 && waited < 20) begin
         @(posedge clk_i);
         #3;
         waited++;
      end
      checkOutput("drain outstanding", 32'(sbQ.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/toast_wb_arbiter.md
Name: toast_wb_arbiter

Overview:
- Owns the single register-file write port.
- Shares that port between the in-order pipeline writeback (the WB stage's rd addr/data/en) and a long-latency unit (LU: divider/CSR) that completes out of band.
- Pipeline writes normally take priority. LU results are buffered in a small FIFO and drained in idle WB slots. A starvation counter forces a drain by stalling WB.
- Sits between the WB stage outputs and the register file write port.

Parameters:
- FIFO_DEPTH, 2, number of buffered LU results (power of 2, >=2).
- STARVE_LIMIT, 4, consecutive cycles the FIFO head may lose arbitration before WB is stalled (>=1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- WB_rd_addr_i  in  5  pipeline writeback destination
- WB_rd_wr_data_i  in  32  pipeline writeback data
- WB_rd_wr_en_i  in  1  pipeline writeback request
- WB_stall_o  out  1  pipeline must hold its WB inputs this cycle
- LU_valid_i  in  1  LU result valid
- LU_rd_addr_i  in  5  LU destination
- LU_data_i  in  32  LU result
- LU_ready_o  out  1  FIFO can accept an LU result
- LU_pending_o  out  1  FIFO non-empty (for hazard/scoreboard use)
- RF_rd_addr_o  out  5  register file write address
- RF_wr_data_o  out  32  register file write data
- RF_wr_en_o  out  1  register file write enable

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous, active-high.
- Reset:
  - RF_* outputs are 0; FIFO is empty; starve_cnt is 0.
  - WB_stall_o, LU_pending_o and LU_ready_o are 0 while rst_i is high.
  - LU_ready_o is 1 from the first cycle after reset.
  - A reset mid-operation discards all buffered entries with no write.
- Outputs RF_* are registered: a granted request appears on RF_* exactly 1 cycle later. With no grant, RF_wr_en_o=0 and addr/data hold their last value.
- Requests:
  - pipe_req = WB_rd_wr_en_i & (WB_rd_addr_i != 0) & ~WB_stall_o.
  - head_req = FIFO non-empty.
  - Writes to x0 are never emitted. LU results for x0 are accepted and stored invalid.
- Stall:
  - WB_stall_o = (starve_cnt == STARVE_LIMIT) & head_req.
  - Driven only from registered state; no combinational path from inputs.
  - While WB_stall_o=1, WB_* inputs are ignored and the pipeline holds them.
- Grant priority, evaluated each cycle:
  1. WB_stall_o: grant the FIFO head (pop).
  2. pipe_req: grant the pipeline.
  3. head_req: grant the FIFO head (pop).
  4. Otherwise: no grant.
- Popping an entry whose valid bit is 0 consumes the slot and produces RF_wr_en_o=0 the next cycle.
- Starvation counter starve_cnt (width clog2(STARVE_LIMIT+1)):
  - Increments when head_req & pipeline granted.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- FIFO:
  - LU_ready_o = ~full, from registered count.
  - Push when LU_valid_i & LU_ready_o.
  - When full, no push even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full: count is unchanged.
  - No bypass: a pushed result is poppable the following cycle at the earliest.
  - Pointers wrap modulo FIFO_DEPTH.
- WAW ordering (LU results are always older than the concurrent pipeline write):
  - If the pipeline is granted with rd == X, every FIFO entry with rd X has its valid bit cleared the same cycle.
  - An LU result pushed that same cycle with rd X is stored invalid.
- LU_pending_o = FIFO non-empty, including invalid entries.

Decomposition:
- toast_pkg holds:
  - wb_req_t struct {logic valid; logic [4:0] addr; logic [31:0] data}.
  - Constants REG_ADDR_W=5 and XLEN=32.
- Sub-module toast_wb_fifo is a parameterised circular buffer of wb_req_t with push/pop, full/empty, and a per-entry valid-clear port driven by an rd-match input.
- Arbitration, the starvation counter and the output registers live in the top module.

Test Plan:
- Reset, then a pipeline write (x5, 0xDEADBEEF) -> RF writes x5=0xDEADBEEF 1 cycle later, WB_stall_o=0, LU_ready_o=1.
- LU result (x7, 0x11) with the pipeline idle -> push at t, RF write x7=0x11 at t+2, LU_pending_o low at t+2.
- LU result x7 pushed, pipeline writes x1..x4 back-to-back with STARVE_LIMIT=4:
  - WB_stall_o=1 on the 5th cycle and x7 is written then.
  - The held pipeline write lands on the following cycle and no write is lost.
- Fill the FIFO with 2 LU results under continuous pipeline writes -> LU_ready_o=0 and a 3rd LU_valid_i is not accepted. After a pop, LU_ready_o=1 and the 3rd result is accepted.
- LU x9=0xAA buffered, then pipeline writes x9=0xBB -> RF has x9=0xBB and the entry pops with RF_wr_en_o=0. The same occurs for a same-cycle push and pipeline write to x9.
- Pipeline write to x0 and LU result to x0 -> RF_wr_en_o never asserts. Assert rst_i with 2 entries buffered -> FIFO empty, no RF writes afterwards.
